mode_counter: RTL and testbench
===============================

Name: mode_counter

Overview:
- Synchronous WIDTH-bit counter with four operating modes: up by 1, down by 1, down by 3, and parallel load.
- Registered ripple-carry/borrow flag RCO allows counters to be cascaded.
- Written behaviourally so it can be synthesised onto the team's cell set (BUF/NOT/NAND/NOR/DFF).
- Sits downstream of the cell library as the first sequential consumer of its flip-flops and gates.

Parameters:
- WIDTH, 4, counter width in bits; legal range WIDTH >= 2.

Ports:
- C  input  1  clock; all state updates on posedge C.
- R  input  1  reset, synchronous, active-high.
- ENB  input  1  count enable; 0 = hold.
- MODE  input  2  operation select; sampled on posedge C.
- D  input  WIDTH  parallel load value, used only when MODE=11.
- Q  output  WIDTH  counter value, registered.
- RCO  output  1  ripple carry/borrow, registered; one-cycle pulse.

Behaviour:
- Reset: at posedge C with R=1, Q <= 0 and RCO <= 0. R overrides ENB, MODE and D. R asserted mid-count aborts the count at that edge; no pending RCO survives.
- Hold: at posedge C with R=0 and ENB=0, Q holds its value and RCO <= 0. RCO is never held high for more than one cycle.
- With R=0 and ENB=1, the operation depends on MODE. All arithmetic is modulo 2^WIDTH.
  - MODE=00 (up 1): Q <= Q+1. RCO <= 1 iff old Q = 2^WIDTH-1 (wrap to 0).
  - MODE=01 (down 1): Q <= Q-1. RCO <= 1 iff old Q = 0 (wrap to all ones).
  - MODE=10 (down 3): Q <= Q-3. RCO <= 1 iff old Q < 3 (borrow).
    - WIDTH=4 wrap results: 2->15, 1->14, 0->13.
  - MODE=11 (load): Q <= D and RCO <= 0, whatever the value of D.
- Latency and timing:
  - Q and RCO update on the same edge, so RCO=1 is visible in the cycle the wrapped Q is visible.
  - Latency from sampled inputs to outputs is one clock.
  - No combinational path from inputs to outputs.
- Switching modes between consecutive cycles needs no idle cycle. Each edge uses only the MODE sampled at that edge and the current Q.
- No internal state other than Q and RCO; there is no FSM beyond the mode decode.
- Cascading: RCO of stage n drives ENB of stage n+1. Both stages run in the same MODE (00/01/10 only); the upper stage advances one cycle after the lower stage wraps.
  - This is a documented one-cycle skew, not a bug.
- X handling: with X on ENB or MODE and R=0, Q may go X; after R=1 for one edge, Q=0 and RCO=0.
- Power-up: Q and RCO are undefined until the first edge with R=1. The bench must apply reset first.

Test Plan:
1. Reset then up count: R=1 for 2 edges, then ENB=1, MODE=00 for 17 edges.
   -> Q steps 0,1,...,15,0,1.
   -> RCO=1 only in the cycle Q=0 after 15, otherwise 0.
2. Down by 1 wrap: load D=4'h2 (MODE=11), then MODE=01 for 4 edges.
   -> Q=2,1,0,15,14.
   -> RCO=1 only with Q=15.
3. Down by 3 borrow: load D=4'h7, then MODE=10 for 5 edges.
   -> Q=7,4,1,14,11,8.
   -> RCO=1 only with Q=14.
4. Enable/hold and load priority:
   - Q=9, ENB=0 with MODE=00/01/10/11 for 4 edges -> Q stays 9, RCO=0.
   - ENB=1, MODE=11, D=4'hF -> Q=15, RCO=0.
   - Next MODE=00 -> Q=0, RCO=1.
5. Reset mid-operation: counting up at Q=15 with R=1 on that edge -> Q=0, RCO=0. No RCO pulse appears on the following cycle.
6. Cascade: two instances, lower RCO drives upper ENB, MODE=00, 40 edges from reset.
   -> Combined value tracks the count with the upper nibble lagging one cycle after each lower wrap.
   -> Upper Q=2 after edge 34.

Source files
------------

// File: rtl/mode_counter.sv
// mode_counter: WIDTH-bit up1/down1/down3/load counter with registered one-cycle RCO for cascading
// Ports: C clock, R sync active-high reset, ENB count enable (0 = hold),
//        MODE 00 up1 / 01 down1 / 10 down3 / 11 load D, Q count, RCO wrap/borrow pulse.
module mode_counter #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             ENB,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    always_comb begin
        q_d   = !ENB            ? q_q :
                MODE == 2'b00   ? q_q + WIDTH'(1) :
                MODE == 2'b01   ? q_q - WIDTH'(1) :
                MODE == 2'b10   ? q_q - WIDTH'(3) : D;
        // RCO flags the edge that wraps or borrows; it is cleared on any hold or load
        rco_d = ENB && (MODE == 2'b00 ? &q_q :
                        MODE == 2'b01 ? ~|q_q :
                        MODE == 2'b10 ? q_q < WIDTH'(3) : 1'b0);
    end
    always_ff @(posedge C) begin
        if (R) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end
    assign Q   = q_q;
    assign RCO = rco_q;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: table-driven check of mode_counter plus a two-stage cascade sequence
module tb_mode_counter;
    typedef struct {
        logic       r;
        logic       enb;
        logic [1:0] mode;
        logic [3:0] d;
        logic [3:0] q;
        logic       rco;
    } vec_t;
    logic       clk = 1'b0;
    logic       r = 1'b1, enb = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] d = 4'h0;
    logic [3:0] q;
    logic       rco;
    logic       cr = 1'b1;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco;
    int         total = 0, bad = 0;
    vec_t       vecs[$];
    always #5 clk = ~clk;
    mode_counter #(.WIDTH(4)) dut (
        .C(clk), .R(r), .ENB(enb), .MODE(mode), .D(d), .Q(q), .RCO(rco)
    );
    mode_counter #(.WIDTH(4)) lo (
        .C(clk), .R(cr), .ENB(1'b1), .MODE(2'b00), .D(4'h0), .Q(lo_q), .RCO(lo_rco)
    );
    mode_counter #(.WIDTH(4)) hi (
        .C(clk), .R(cr), .ENB(lo_rco), .MODE(2'b00), .D(4'h0), .Q(hi_q), .RCO(hi_rco)
    );
    function automatic void add(input logic vr, input logic ve, input logic [1:0] vm,
                                input logic [3:0] vd, input logic [3:0] vq, input logic vc);
        vec_t v;
        v.r = vr; v.enb = ve; v.mode = vm; v.d = vd; v.q = vq; v.rco = vc;
        vecs.push_back(v);
    endfunction
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask
    initial begin
        logic [3:0] lo_m, hi_m;
        logic       rco_m;
        // reset two edges, then up count 17 edges
        add(1, 0, 2'b00, 4'h0, 4'h0, 0);
        add(1, 0, 2'b00, 4'h0, 4'h0, 0);
        for (int k = 1; k <= 17; k++) add(0, 1, 2'b00, 4'h0, 4'(k), k == 16);
        // down by 1 wrap
        add(0, 1, 2'b11, 4'h2, 4'h2, 0);
        add(0, 1, 2'b01, 4'h0, 4'h1, 0);
        add(0, 1, 2'b01, 4'h0, 4'h0, 0);
        add(0, 1, 2'b01, 4'h0, 4'hF, 1);
        add(0, 1, 2'b01, 4'h0, 4'hE, 0);
        // down by 3 borrow
        add(0, 1, 2'b11, 4'h7, 4'h7, 0);
        add(0, 1, 2'b10, 4'h0, 4'h4, 0);
        add(0, 1, 2'b10, 4'h0, 4'h1, 0);
        add(0, 1, 2'b10, 4'h0, 4'hE, 1);
        add(0, 1, 2'b10, 4'h0, 4'hB, 0);
        add(0, 1, 2'b10, 4'h0, 4'h8, 0);
        // down by 3 wrap results from 2, 1, 0 and boundary 3
        add(0, 1, 2'b11, 4'h2, 4'h2, 0);
        add(0, 1, 2'b10, 4'h0, 4'hF, 1);
        add(0, 1, 2'b11, 4'h1, 4'h1, 0);
        add(0, 1, 2'b10, 4'h0, 4'hE, 1);
        add(0, 1, 2'b11, 4'h0, 4'h0, 0);
        add(0, 1, 2'b10, 4'h0, 4'hD, 1);
        add(0, 1, 2'b11, 4'h3, 4'h3, 0);
        add(0, 1, 2'b10, 4'h0, 4'h0, 0);
        // hold in every mode, then load priority and wrap
        add(0, 1, 2'b11, 4'h9, 4'h9, 0);
        for (int m = 0; m < 4; m++) add(0, 0, 2'(m), 4'h5, 4'h9, 0);
        add(0, 1, 2'b11, 4'hF, 4'hF, 0);
        add(0, 1, 2'b00, 4'h0, 4'h0, 1);
        add(0, 0, 2'b00, 4'h0, 4'h0, 0);
        // load clears RCO right after a wrap
        add(0, 1, 2'b11, 4'hF, 4'hF, 0);
        add(0, 1, 2'b00, 4'h0, 4'h0, 1);
        add(0, 1, 2'b11, 4'h0, 4'h0, 0);
        // reset mid-count at Q=15 suppresses the wrap pulse
        add(0, 1, 2'b11, 4'hF, 4'hF, 0);
        add(1, 1, 2'b00, 4'h0, 4'h0, 0);
        add(0, 0, 2'b00, 4'h0, 4'h0, 0);
        add(0, 1, 2'b00, 4'h0, 4'h1, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            r = vecs[i].r; enb = vecs[i].enb; mode = vecs[i].mode; d = vecs[i].d;
            @(posedge clk);
            #1;
            chk("q", i, 32'(q), 32'(vecs[i].q));
            chk("rco", i, 32'(rco), 32'(vecs[i].rco));
        end
        // cascade: upper stage advances one cycle after each lower wrap
        cr = 1'b1;
        @(posedge clk);
        #1;
        chk("cas_rst_lo", 0, 32'(lo_q), 32'h0);
        chk("cas_rst_hi", 0, 32'(hi_q), 32'h0);
        cr = 1'b0;
        lo_m = 4'h0; hi_m = 4'h0; rco_m = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (rco_m) hi_m = hi_m + 4'h1;
            rco_m = (lo_m == 4'hF);
            lo_m = lo_m + 4'h1;
            chk("cas_lo", e, 32'(lo_q), 32'(lo_m));
            chk("cas_hi", e, 32'(hi_q), 32'(hi_m));
            chk("cas_rco", e, 32'(lo_rco), 32'(rco_m));
            if (e == 34) chk("cas_hi_e34", e, 32'(hi_q), 32'h2);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
